issue_fifo: RTL and testbench
=============================

Name: issue_fifo

Overview:
- Issue-stage instruction buffer; the storage and dequeue end of the allocation protocol.
- Accepts a write whenever the allocator asserts next_wen.
- Publishes a one-hot free-slot pressure vector fifo_pr that the allocator samples to throttle itself.
- Drains in order to the dispatch/pick stage through a valid/ready handshake; supports a single-cycle flush.

Parameters:
- DATA_WIDTH, 64, width of one issue entry payload.
- DEPTH, 16, number of entries; power of two, minimum 16 (must exceed the 8-slot pressure window plus the allocator's 4-cycle stop latency).
- PTR_W, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  discard all entries (pipeline redirect / snoop kill).
- wen  in  1  enqueue strobe; driven by allocator next_wen.
- wdata  in  DATA_WIDTH  entry payload, sampled when wen.
- fifo_pr  out  9  registered one-hot free-slot pressure vector.
- o_valid  out  1  head entry present.
- o_data  out  DATA_WIDTH  head entry payload.
- i_ready  in  1  downstream accepts head this cycle.
- o_overflow  out  1  sticky: write was dropped while full.

Behaviour:
- Reset (async assert, sync release): wptr=rptr=0, count=0, o_valid=0, fifo_pr=0 (free=DEPTH>8), o_overflow=0. o_data is don't-care. The storage array is not reset.
- pop = o_valid & i_ready. push = wen & (count<DEPTH | pop).
- Wen while full and no pop: write dropped, o_overflow set until reset. Flush does not clear o_overflow.
- Push+pop in the same cycle is always legal, including when full and when count==1. count is unchanged.
- Push to an empty queue: o_valid=1 and o_data=wdata on the next cycle (1-cycle latency). No same-cycle bypass.
- o_data is read combinationally from array[rptr]. It holds stable while o_valid & ~i_ready.
- Pointers wrap modulo DEPTH. count has PTR_W+1 bits and ranges 0..DEPTH.
- free_next = DEPTH - count_next.
- fifo_pr is registered from free_next:
  - fifo_pr[k]=1 iff free_next == 8-k, for k=0..8.
  - fifo_pr[8] means full.
  - All zeros when free_next>8.
  - Exactly one bit set otherwise.
- flush has priority over push and pop in the same cycle: wptr=rptr=0, count=0, o_valid=0 next cycle, fifo_pr=0 next cycle. A wen coinciding with flush is discarded and is not an overflow.
- Reset mid-operation: all state is cleared immediately on resetn low. No handshake is completed.
- Design contract: the allocator stops writing 4 cycles after fifo_pr[8:3] is non-zero. issue_fifo does not rely on this; overflow is detected, not prevented.

Decomposition:
- Package issue_pkg:
  - ISSUE_DEPTH=16.
  - ISSUE_PR_W=9.
  - ISSUE_PR_WINDOW=8.
  - ISSUE_STOP_LAT=4.
  - typedef issue_entry_t (DATA_WIDTH payload).
- Sub-module issue_pr_enc: combinational free-count to 9-bit one-hot encoder, shared with any future queue that feeds an allocator.
- Storage is a plain register array inside issue_fifo.

Test Plan:
- Reset, then 16 consecutive wen with i_ready=0 -> after write 8 fifo_pr=9'h001; after write 12 fifo_pr=9'h010; after write 16 fifo_pr=9'h100; o_valid=1; o_data=first word.
- Full with i_ready=0, one extra wen -> data dropped, o_overflow=1 from next cycle, count stays 16, fifo_pr=9'h100.
- Full with wen=1 and i_ready=1 for 20 cycles -> no overflow, fifo_pr stays 9'h100, popped sequence matches push order across pointer wrap.
- Empty, single wen with data 0xA5 -> o_valid=0 same cycle, o_valid=1 and o_data=0xA5 next cycle; i_ready=1 pops it, o_valid=0 the cycle after.
- 10 entries, then flush with wen=1 and i_ready=1 -> next cycle o_valid=0, fifo_pr=0, count=0, o_overflow unchanged; next push lands at index 0.
- resetn pulsed low asynchronously mid-stream (between clock edges) -> o_valid, fifo_pr and o_overflow go 0 without waiting for a clock edge; normal operation resumes after release.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared constants and types for the issue-stage queue.
// Imported by the queue, its interface and its pressure encoder.
package issue_pkg;

  localparam int ISSUE_DEPTH     = 16;
  localparam int ISSUE_PR_W      = 9;
  localparam int ISSUE_PR_WINDOW = 8;
  localparam int ISSUE_STOP_LAT  = 4;
  localparam int ISSUE_DATA_W    = 64;

  typedef logic [ISSUE_DATA_W-1:0] issue_entry_t;

endpackage

// File: rtl/issue_fifo_if.sv
// Allocator-side enqueue and dispatch-side dequeue bundle.
// master = allocator + pick stage, slave = issue_fifo.
interface issue_fifo_if
  import issue_pkg::*;
#(
  parameter int DATA_WIDTH = ISSUE_DATA_W
);

  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ISSUE_PR_W-1:0] fifo_pr;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  i_ready;

  modport master (
    output wen, wdata, i_ready,
    input  fifo_pr, o_valid, o_data
  );

  modport slave (
    input  wen, wdata, i_ready,
    output fifo_pr, o_valid, o_data
  );

endinterface

// File: rtl/issue_pr_enc.sv
// Free-slot count to one-hot pressure vector.
// Bit k set when exactly 8-k slots are free; zero above the window.
module issue_pr_enc
  import issue_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic [CNT_W-1:0]      free,
  output logic [ISSUE_PR_W-1:0] pr
);

  // One-hot match of free count against the pressure window
  always_comb begin
    pr = '0;
    for (int k = 0; k <= ISSUE_PR_WINDOW; k++) begin
      if (free == CNT_W'(ISSUE_PR_WINDOW - k)) pr[k] = 1'b1;
    end
  end

endmodule

// File: rtl/issue_fifo.sv
// Issue-stage instruction buffer with allocator pressure output.
// In-order drain via valid/ready; flush clears all entries.
module issue_fifo
  import issue_pkg::*;
#(
  parameter  int DATA_WIDTH = ISSUE_DATA_W,
  parameter  int DEPTH      = ISSUE_DEPTH,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  issue_fifo_if.slave   q,
  output logic          o_overflow
);

  // Window plus stop latency must fit, else writes in flight overflow
  if (DEPTH < ISSUE_DEPTH ||
      DEPTH <= ISSUE_PR_WINDOW + ISSUE_STOP_LAT ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("issue_fifo: DEPTH must be a power of two >= 16");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic [CNT_W-1:0]      free_next;
  logic [ISSUE_PR_W-1:0] pr_next;
  logic [ISSUE_PR_W-1:0] pr_q;
  logic                  pop;
  logic                  push;
  logic                  wr;
  logic                  drop;

  assign q.o_valid = |count;
  assign q.o_data  = mem[rptr];
  assign q.fifo_pr = pr_q;

  assign pop  = q.o_valid & q.i_ready;
  assign push = q.wen & ((count < CNT_W'(DEPTH)) | pop);
  assign wr   = push & ~flush;
  assign drop = q.wen & ~push & ~flush;

  assign count_next = flush ? '0
                    : count + CNT_W'(push) - CNT_W'(pop);
  assign free_next  = CNT_W'(DEPTH) - count_next;

  issue_pr_enc #(
    .CNT_W (CNT_W)
  ) u_pr_enc (
    .free (free_next),
    .pr   (pr_next)
  );

  // Pointers, occupancy, pressure and sticky overflow
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      pr_q       <= '0;
      o_overflow <= 1'b0;
    end else begin
      count <= count_next;
      pr_q  <= pr_next;
      if (drop) o_overflow <= 1'b1;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + PTR_W'(1);
        if (pop)  rptr <= rptr + PTR_W'(1);
      end
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= q.wdata;
  end

endmodule

// File: tb/tb_issue_fifo.sv
// Directed + random bench for issue_fifo.
// Queue-based reference model, immediate-assert checks.
module tb_issue_fifo;

  localparam int DW    = 64;
  localparam int DEPTH = 16;

  logic clk;
  logic resetn;
  logic flush;
  logic ovf;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mq [$];
  logic          ov_m;

  issue_fifo_if #(.DATA_WIDTH(DW)) bus ();

  issue_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .q          (bus.slave),
    .o_overflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] exp_pr(input int free);
    logic [8:0] one;
    one = 9'd1;
    if (free > 8) return 9'd0;
    return one << (8 - free);
  endfunction

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("o_valid", DW'(bus.o_valid), DW'(mq.size() != 0));
    chk("fifo_pr", DW'(bus.fifo_pr), DW'(exp_pr(DEPTH - mq.size())));
    chk("o_overflow", DW'(ovf), DW'(ov_m));
    if (mq.size() != 0) chk("o_data", bus.o_data, mq[0]);
  endtask

  // Called at a falling edge: drive, model one rising edge, check
  task automatic cyc(input logic w, input logic [DW-1:0] d,
                     input logic r, input logic f);
    bit pop_m;
    bit push_m;
    logic [DW-1:0] tmp;
    bus.wen     = w;
    bus.wdata   = d;
    bus.i_ready = r;
    flush       = f;
    pop_m = (mq.size() != 0) && r;
    if (f) begin
      mq.delete();
    end else begin
      push_m = w && (mq.size() < DEPTH || pop_m);
      if (w && !push_m) ov_m = 1'b1;
      if (pop_m) tmp = mq.pop_front();
      if (push_m) mq.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [DW-1:0] first;
    logic [DW-1:0] d;

    resetn      = 1'b0;
    flush       = 1'b0;
    bus.wen     = 1'b0;
    bus.wdata   = '0;
    bus.i_ready = 1'b0;
    ov_m        = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    check_outputs();
    chk("reset_pr", DW'(bus.fifo_pr), DW'(0));

    // Fill 16 with no consumer
    first = rnd();
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, (i == 1) ? first : rnd(), 1'b0, 1'b0);
      if (i == 8)  chk("pr_w8",  DW'(bus.fifo_pr), DW'(9'h001));
      if (i == 12) chk("pr_w12", DW'(bus.fifo_pr), DW'(9'h010));
      if (i == 16) chk("pr_w16", DW'(bus.fifo_pr), DW'(9'h100));
    end
    chk("full_valid", DW'(bus.o_valid), DW'(1));
    chk("full_head", bus.o_data, first);

    // Full with simultaneous push and pop, across pointer wrap
    for (int i = 0; i < 20; i++) cyc(1'b1, rnd(), 1'b1, 1'b0);
    chk("pp_no_ovf", DW'(ovf), DW'(0));
    chk("pp_pr", DW'(bus.fifo_pr), DW'(9'h100));

    // Extra write while full and stalled
    cyc(1'b1, rnd(), 1'b0, 1'b0);
    chk("ovf_set", DW'(ovf), DW'(1));
    chk("ovf_pr", DW'(bus.fifo_pr), DW'(9'h100));
    cyc(1'b0, '0, 1'b0, 1'b0);

    // Flush to empty, then single-entry latency
    cyc(1'b0, '0, 1'b0, 1'b1);
    bus.wen   = 1'b1;
    bus.wdata = DW'(8'hA5);
    flush     = 1'b0;
    #1;
    chk("no_bypass", DW'(bus.o_valid), DW'(0));
    cyc(1'b1, DW'(8'hA5), 1'b0, 1'b0);
    chk("a5_data", bus.o_data, DW'(8'hA5));
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("a5_popped", DW'(bus.o_valid), DW'(0));

    // Ten entries, then flush colliding with push and pop
    for (int i = 0; i < 10; i++) cyc(1'b1, rnd(), 1'b0, 1'b0);
    cyc(1'b1, rnd(), 1'b1, 1'b1);
    chk("fl_valid", DW'(bus.o_valid), DW'(0));
    chk("fl_pr", DW'(bus.fifo_pr), DW'(0));
    chk("fl_ovf_kept", DW'(ovf), DW'(1));
    d = rnd();
    cyc(1'b1, d, 1'b0, 1'b0);
    chk("fl_next", bus.o_data, d);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, rnd(),
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 40) == 0);
    end

    // Ensure queue non-empty before async reset
    for (int i = 0; i < 5; i++) cyc(1'b1, rnd(), 1'b0, 1'b0);
    bus.wen     = 1'b0;
    bus.i_ready = 1'b0;
    flush       = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("ar_valid", DW'(bus.o_valid), DW'(0));
    chk("ar_pr", DW'(bus.fifo_pr), DW'(0));
    chk("ar_ovf", DW'(ovf), DW'(0));
    mq.delete();
    ov_m = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check_outputs();

    // Resume after release
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 1) == 0, rnd(),
          $urandom_range(0, 3) == 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
